// File: rtl/trace_feeder.sv
// rtl/trace_feeder.sv - replays a ROM-held address trace into the cache, one acknowledged access at a time
// Optional TRACE_TIMEOUT_EN: bounded wait for updated, sticky timeout_err, skip of the stalled entry.
module trace_feeder #(
  parameter int TRACE_DEPTH = 1024,
  parameter int PTR_W       = $clog2(TRACE_DEPTH)
`ifdef TRACE_TIMEOUT_EN
  , parameter int TIMEOUT   = 255
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PTR_W:0]   trace_len,
  output logic             rom_en,
  output logic [PTR_W-1:0] rom_addr,
  input  logic [31:0]      rom_data,
  output logic [31:0]      mem_addr,
  output logic             trace_ready,
  input  logic             updated,
  output logic             busy,
  output logic             done,
  output logic [19:0]      access_count
`ifdef TRACE_TIMEOUT_EN
  , output logic           timeout_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_WAIT_ACK, S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [PTR_W:0] ptr, len, ptr_inc;
  logic           ack, tmo_hit, advance, launch, last;

`ifdef TRACE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
`endif

  assign rom_addr = ptr[PTR_W-1:0];

  always_comb begin
    ptr_inc = ptr + (PTR_W + 1)'(1);
    ack     = ((state == S_ISSUE) || (state == S_WAIT_ACK)) && updated;
    launch  = ((state == S_IDLE) || (state == S_DONE)) && start;
    // ptr is one bit wider than the ROM index so a full-depth trace ends cleanly
    last    = (ptr_inc == len);
`ifdef TRACE_TIMEOUT_EN
    tmo_hit = (state == S_WAIT_ACK) && !updated && (tmo_cnt == TMO_W'(TIMEOUT));
`else
    tmo_hit = 1'b0;
`endif
    advance = ack || tmo_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (trace_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:        state_nxt = S_LOAD;
      S_LOAD:         state_nxt = S_ISSUE;
      S_ISSUE:        state_nxt = advance ? (last ? S_DONE : S_FETCH) : S_WAIT_ACK;
      S_WAIT_ACK:     if (advance) state_nxt = last ? S_DONE : S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rom_en      = (state == S_FETCH);
    trace_ready = (state == S_ISSUE);
    busy        = (state != S_IDLE) && (state != S_DONE);
    done        = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      len          <= '0;
      mem_addr     <= '0;
      access_count <= '0;
    end else begin
      if (launch) begin
        len          <= trace_len;
        ptr          <= '0;
        access_count <= '0;
      end
      if (state == S_LOAD) mem_addr <= rom_data;
      if (advance) begin
        ptr <= ptr_inc;
        if (ack && (access_count != 20'hFFFFF)) access_count <= access_count + 20'd1;
      end
    end
  end

`ifdef TRACE_TIMEOUT_EN
  // tmo_cnt holds the number of cycles elapsed since the strobe while in WAIT_ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ISSUE)         tmo_cnt <= TMO_W'(1);
      else if (state == S_WAIT_ACK) tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (launch)       timeout_err <= 1'b0;
      else if (tmo_hit) timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_trace_feeder.sv
// tb/tb_trace_feeder.sv - scoreboard bench for trace_feeder (optional TRACE_TIMEOUT_EN scenario)
module tb_trace_feeder;
  localparam int DEPTH = 1024;
  localparam int PW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW:0]   trace_len = '0;
  logic          rom_en;
  logic [PW-1:0] rom_addr;
  logic [31:0]   rom_data = '0;
  logic [31:0]   mem_addr;
  logic          trace_ready;
  logic          updated;
  logic          busy, done;
  logic [19:0]   access_count;
`ifdef TRACE_TIMEOUT_EN
  logic          timeout_err;
`endif

  trace_feeder #(
    .TRACE_DEPTH(DEPTH)
`ifdef TRACE_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trace_len(trace_len),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_addr(mem_addr), .trace_ready(trace_ready), .updated(updated),
    .busy(busy), .done(done), .access_count(access_count)
`ifdef TRACE_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rom [0:DEPTH-1];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

  logic          ack_same = 1'b0, upd_drv = 1'b0;
  int            ack_delay = 2, hold_idx = -1, pending = 0, run_strobes = 0, rom_en_cnt = 0, tmo_cyc = -1;
  logic [PW-1:0] last_rom_addr = '0;
  logic [31:0]   exp_q[$], got_q[$];
  int            strobe_cyc[$];
  int            pass_cnt = 0, total_cnt = 0;

  assign updated = ack_same ? trace_ready : upd_drv;

  // cache model and observer: acks ack_delay cycles after each strobe, except strobe hold_idx
  initial forever begin
    @(negedge clk);
    upd_drv = 1'b0;
    if (pending > 0) begin
      pending--;
      if (pending == 0) upd_drv = 1'b1;
    end
    if (rst_n && trace_ready) begin
      got_q.push_back(mem_addr);
      strobe_cyc.push_back(cyc);
      if (!ack_same && run_strobes != hold_idx) pending = ack_delay;
      run_strobes++;
    end
    if (rst_n && rom_en) begin
      rom_en_cnt++;
      last_rom_addr = rom_addr;
    end
`ifdef TRACE_TIMEOUT_EN
    if (timeout_err && tmo_cyc < 0) tmo_cyc = cyc;
`endif
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic start_run(input int len);
    exp_q.delete(); got_q.delete(); strobe_cyc.delete();
    run_strobes = 0; rom_en_cnt = 0; pending = 0; tmo_cyc = -1;
    for (int i = 0; i < len; i++) exp_q.push_back(rom[i]);
    @(negedge clk);
    trace_len = (PW + 1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!done) $display("FAIL %s_done_timeout got done=%0b exp=1 after %0d cycles", name, done, n);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({mem_addr, rom_addr, rom_en, trace_ready, busy, done, access_count} !== '0)
      $display("FAIL reset_outputs got mem_addr=%h rom_addr=%0d rom_en=%0b tr=%0b busy=%0b done=%0b cnt=%0d exp=all 0",
               mem_addr, rom_addr, rom_en, trace_ready, busy, done, access_count);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int c1;
    ack_same = 1'b0; ack_delay = 2; hold_idx = -1;
    start_run(3);
    c1 = cyc;
    total_cnt++;
    if (rom_en !== 1'b1) $display("FAIL basic_fetch_cycle1 got rom_en=%0b exp=1", rom_en); else pass_cnt++;
    wait_done(100, "basic");
    total_cnt++;
    if (got_q.size() != 3) $display("FAIL basic_strobes got=%0d exp=3", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL basic_addr%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (strobe_cyc[0] != c1 + 2) $display("FAIL basic_first_strobe got cycle=%0d exp=%0d", strobe_cyc[0], c1 + 2);
    else pass_cnt++;
    total_cnt++;
    if (access_count !== 20'd3) $display("FAIL basic_count got=%0d exp=3", access_count); else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL basic_busy got=%0b exp=0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int dc;
    ack_same = 1'b1;
    start_run(4);
    wait_done(100, "b2b");
    dc = cyc;
    total_cnt++;
    if (strobe_cyc.size() != 4) $display("FAIL b2b_strobes got=%0d exp=4", strobe_cyc.size());
    else begin
      pass_cnt++;
      for (int i = 1; i < 4; i++) begin
        total_cnt++;
        if (strobe_cyc[i] - strobe_cyc[i-1] != 3)
          $display("FAIL b2b_gap%0d got=%0d exp=3", i, strobe_cyc[i] - strobe_cyc[i-1]);
        else pass_cnt++;
      end
      total_cnt++;
      if (dc - strobe_cyc[3] != 1) $display("FAIL b2b_done_lat got=%0d exp=1", dc - strobe_cyc[3]); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL b2b_addr%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    ack_same = 1'b0;
  endtask

  task automatic test_zero_len;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL zero_pre_done got=%0b exp=0", done); else pass_cnt++;
    start_run(0);
    total_cnt++;
    if (done !== 1'b1) $display("FAIL zero_done_next got=%0b exp=1", done); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (rom_en_cnt != 0 || got_q.size() != 0)
      $display("FAIL zero_activity got rom_en=%0d strobes=%0d exp=0/0", rom_en_cnt, got_q.size());
    else pass_cnt++;
    total_cnt++;
    if (access_count !== 20'd0 || busy !== 1'b0)
      $display("FAIL zero_state got cnt=%0d busy=%0b exp=0/0", access_count, busy);
    else pass_cnt++;
  endtask

  task automatic test_full;
    int mism = 0;
    ack_same = 1'b1;
    start_run(DEPTH);
    wait_done(5000, "full");
    total_cnt++;
    if (got_q.size() != DEPTH) $display("FAIL full_strobes got=%0d exp=%0d", got_q.size(), DEPTH); else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) if (got_q[i] !== exp_q[i]) mism++;
    total_cnt++;
    if (mism != 0) $display("FAIL full_addrs got mismatches=%0d exp=0", mism); else pass_cnt++;
    total_cnt++;
    if (rom_en_cnt != DEPTH || last_rom_addr !== 10'd1023)
      $display("FAIL full_rom got fetches=%0d last=%0d exp=%0d/1023", rom_en_cnt, last_rom_addr, DEPTH);
    else pass_cnt++;
    total_cnt++;
    if (access_count !== 20'd1024) $display("FAIL full_count got=%0d exp=1024", access_count); else pass_cnt++;
    ack_same = 1'b0;
  endtask

  task automatic test_reset_abort;
    int n = 0, seen;
    ack_delay = 2; hold_idx = 5;
    start_run(10);
    while (run_strobes < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || trace_ready !== 1'b0 || run_strobes != 6)
      $display("FAIL abort_waiting got busy=%0b tr=%0b strobes=%0d exp=1/0/6", busy, trace_ready, run_strobes);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_addr, rom_addr, rom_en, trace_ready, busy, done, access_count} !== '0)
      $display("FAIL abort_outputs got mem_addr=%h rom_addr=%0d busy=%0b cnt=%0d exp=all 0",
               mem_addr, rom_addr, busy, access_count);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    hold_idx = -1;
    seen = got_q.size();
    repeat (10) @(negedge clk);
    total_cnt++;
    if (got_q.size() != seen) $display("FAIL abort_no_strobe got=%0d exp=%0d", got_q.size(), seen); else pass_cnt++;
    start_run(3);
    wait_done(100, "restart");
    total_cnt++;
    if (got_q[0] !== rom[0] || got_q.size() != 3)
      $display("FAIL restart_entry0 got=%h n=%0d exp=%h n=3", got_q[0], got_q.size(), rom[0]);
    else pass_cnt++;
    total_cnt++;
    if (access_count !== 20'd3) $display("FAIL restart_count got=%0d exp=3", access_count); else pass_cnt++;
  endtask

`ifdef TRACE_TIMEOUT_EN
  task automatic test_timeout;
    ack_delay = 2; hold_idx = 1;
    start_run(3);
    wait_done(200, "timeout");
    total_cnt++;
    if (strobe_cyc.size() != 3) $display("FAIL tmo_strobes got=%0d exp=3", strobe_cyc.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (tmo_cyc != strobe_cyc[1] + 9)
        $display("FAIL tmo_rise got cycle=%0d exp=%0d", tmo_cyc, strobe_cyc[1] + 9);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (got_q[i] !== exp_q[i]) $display("FAIL tmo_addr%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (timeout_err !== 1'b1 || access_count !== 20'd2)
      $display("FAIL tmo_final got err=%0b cnt=%0d exp=1/2", timeout_err, access_count);
    else pass_cnt++;
    hold_idx = -1;
    start_run(0);
    total_cnt++;
    if (timeout_err !== 1'b0) $display("FAIL tmo_clear got=%0b exp=0", timeout_err); else pass_cnt++;
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'h1000_0000 | (i << 4);
    rom[0] = 32'h0000_0010;
    rom[1] = 32'h0000_8010;
    rom[2] = 32'h0000_0010;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_len();
    test_full();
    test_reset_abort();
`ifdef TRACE_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/trace_feeder.md
# trace_feeder

Upstream stage of the cache simulator top level: walks a memory-address trace held in a synchronous ROM/BRAM and presents one 32-bit address at a time on `mem_addr`, with a one-cycle `trace_ready` strobe. It then waits for the cache's `updated` acknowledge before fetching the next entry. It counts issued accesses and flags completion so the hit/miss counters can be read out once the whole trace has been consumed.

## Interface
- `TRACE_DEPTH`, 1024: number of ROM entries; must be a power of two ≥ 2.
- `PTR_W`, `$clog2(TRACE_DEPTH)`: ROM address width.
- `TIMEOUT`, 255: maximum cycles to wait for `updated`; only used with `TRACE_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled start request.
- `trace_len` in `PTR_W+1`: number of entries to replay (0..`TRACE_DEPTH`); sampled when `start` is accepted.
- `rom_en` out 1: ROM read enable.
- `rom_addr` out `PTR_W`: ROM read address.
- `rom_data` in 32: ROM read data, valid one cycle after `rom_en`.
- `mem_addr` out 32: address to the cache; registered.
- `trace_ready` out 1: one-cycle strobe, "`mem_addr` is valid, process it".
- `updated` in 1: one-cycle acknowledge from the cache that the access is resolved (hit or fill done).
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high while in DONE.
- `access_count` out 20: accesses acknowledged; saturates at 20'hFFFFF.
- `timeout_err` out 1: sticky flag; exists only with `TRACE_TIMEOUT_EN`.

## Operation
- State machine: IDLE, FETCH, LOAD, ISSUE, WAIT_ACK, DONE.
- IDLE:
  - `start`=1 latches `trace_len`, clears `ptr` and `access_count`.
  - Goes to FETCH, or straight to DONE if `trace_len`=0.
- FETCH: `rom_en`=1, `rom_addr`=`ptr`; go to LOAD.
- LOAD: register `rom_data` into `mem_addr`; go to ISSUE.
- ISSUE:
  - `trace_ready`=1 for this single cycle.
  - If `updated`=1 in this same cycle, treat it as the acknowledge (see below).
  - Otherwise go to WAIT_ACK.
- WAIT_ACK: hold `mem_addr` stable until `updated`=1.
- On acknowledge:
  - Increment `access_count` (saturating) and `ptr`.
  - If the incremented `ptr` equals the latched length, go to DONE; otherwise go to FETCH.
- DONE:
  - `done`=1 and `mem_addr` keeps the last address.
  - `start`=1 restarts exactly as from IDLE. Clear `timeout_err` too when `TRACE_TIMEOUT_EN` is defined.
- `start` is ignored while `busy`.
- `updated` is ignored outside ISSUE and WAIT_ACK.
- `ptr` width is `PTR_W+1`, so `trace_len`=`TRACE_DEPTH` terminates without wrapping. `rom_addr` is `ptr[PTR_W-1:0]`.

## Timing
- Reset (async assert, sync release to IDLE): all outputs are 0. That covers `mem_addr`, `rom_addr`, `rom_en`, `trace_ready`, `busy`, `done`, `access_count` and `timeout_err`.
- Asserting `rst_n` mid-trace aborts immediately. No further `trace_ready` is issued until a new `start`.
- Cycle 0 is `start` sampled high in IDLE:
  - Cycle 1: FETCH, `rom_en` high.
  - Cycle 2: LOAD.
  - Cycle 3: ISSUE, `trace_ready` high, `mem_addr` already valid.
- Per-entry cost is 3 cycles plus the cache's acknowledge latency. The minimum period between `trace_ready` strobes is 3 cycles, reached when `updated` coincides with `trace_ready`.
- `done` rises the cycle after the last acknowledge.
- `access_count` updates the cycle after each acknowledge.

## Configuration
- `TRACE_TIMEOUT_EN` defined:
  - A counter runs in WAIT_ACK. If `updated` is not seen within `TIMEOUT` cycles of the strobe, set `timeout_err`.
  - The entry is then skipped without incrementing `access_count`; `ptr` still advances, with normal FETCH/DONE selection.
- `TRACE_TIMEOUT_EN` undefined: no counter and no `timeout_err` port. WAIT_ACK waits indefinitely.

## Test plan
- ROM entries {0x0000_0010, 0x0000_8010, 0x0000_0010}, `trace_len`=3, `updated` 2 cycles after each strobe. Required: 3 strobes with those addresses in order, `access_count`=3, `done`=1, `busy`=0.
- `updated` tied to `trace_ready` (same-cycle ack), `trace_len`=4. Required: strobes exactly 3 cycles apart, `done` 1 cycle after the 4th.
- `trace_len`=0 with `start`. Required: DONE next cycle, no `rom_en`, no `trace_ready`, `access_count`=0.
- `trace_len`=`TRACE_DEPTH`=1024. Required: `rom_addr` reaches 1023, 1024 strobes, no wrap to entry 0, `done`=1.
- `rst_n` low for one cycle while in WAIT_ACK on entry 5 of 10. Required: all outputs 0 immediately, no strobe until `start`; the restart replays from entry 0.
- With `TRACE_TIMEOUT_EN`, `TIMEOUT`=8, `updated` withheld on entry 1 of 3. Required: `timeout_err`=1 after 8 cycles, trace continues, final `access_count`=2, `done`=1.
